// File: rtl/triangle_vertex_unpacker.sv
// triangle_vertex_unpacker: captures one packed 3-vertex triangle, streams its vertices, then its x/y bbox.
// Optional build macro DEGEN_CULL_EN drops triangles in which two vertices share the same (x,y).

module tvu_vertex_unpack #(
  parameter  int COORD_W = 16,
  parameter  int COLOR_W = 8,
  localparam int VTX_W   = 3*COORD_W + COLOR_W
) (
  input  logic [VTX_W-1:0]   vtx,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] z,
  output logic [COLOR_W-1:0] color
);
  assign x     = vtx[VTX_W-1 -: COORD_W];
  assign y     = vtx[VTX_W-COORD_W-1 -: COORD_W];
  assign z     = vtx[COLOR_W +: COORD_W];
  assign color = vtx[COLOR_W-1:0];
endmodule

module triangle_vertex_unpacker #(
  parameter  int COORD_W = 16,
  parameter  int COLOR_W = 8,
  parameter  int CNT_W   = 16,
  localparam int VTX_W   = 3*COORD_W + COLOR_W,
  localparam int TRI_W   = 3*VTX_W
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [TRI_W-1:0]   texel_buffer,
  input  logic               texel_ready,
  output logic               texel_read,
  output logic [COORD_W-1:0] vtx_x,
  output logic [COORD_W-1:0] vtx_y,
  output logic [COORD_W-1:0] vtx_z,
  output logic [COLOR_W-1:0] vtx_color,
  output logic [1:0]         vtx_idx,
  output logic               vtx_valid,
  input  logic               vtx_ready,
  output logic [COORD_W-1:0] bbox_xmin,
  output logic [COORD_W-1:0] bbox_xmax,
  output logic [COORD_W-1:0] bbox_ymin,
  output logic [COORD_W-1:0] bbox_ymax,
  output logic               bbox_valid,
  input  logic               bbox_ready,
  output logic [CNT_W-1:0]   tri_count,
  output logic [CNT_W-1:0]   cull_count
);
  localparam int NUM_VTX = 3;

  typedef enum logic [1:0] {IDLE, CHECK, EMIT, BBOX} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] ymax;
  } bbox_t;

  state_t state, state_n;
  logic [TRI_W-1:0] tri_q;
  logic [1:0]       idx;
  bbox_t            bbox_d, bbox_q;
  logic [CNT_W-1:0] tri_q_cnt;
  logic             degen;

  logic [NUM_VTX-1:0][COORD_W-1:0] vx, vy, vz;
  logic [NUM_VTX-1:0][COLOR_W-1:0] vc;

  for (genvar k = 0; k < NUM_VTX; k++) begin : g_vtx
    tvu_vertex_unpack #(.COORD_W(COORD_W), .COLOR_W(COLOR_W)) u_unpack (
      .vtx  (tri_q[VTX_W*k +: VTX_W]),
      .x    (vx[k]),
      .y    (vy[k]),
      .z    (vz[k]),
      .color(vc[k])
    );
  end

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  always_comb begin
    bbox_d.xmin = min3(vx[0], vx[1], vx[2]);
    bbox_d.xmax = max3(vx[0], vx[1], vx[2]);
    bbox_d.ymin = min3(vy[0], vy[1], vy[2]);
    bbox_d.ymax = max3(vy[0], vy[1], vy[2]);
  end

`ifdef DEGEN_CULL_EN
  assign degen = ({vx[0], vy[0]} == {vx[1], vy[1]}) ||
                 ({vx[0], vy[0]} == {vx[2], vy[2]}) ||
                 ({vx[1], vy[1]} == {vx[2], vy[2]});
`else
  assign degen = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    texel_read = 1'b0;
    vtx_valid  = 1'b0;
    bbox_valid = 1'b0;
    case (state)
      IDLE:  if (texel_ready) state_n = CHECK;
      CHECK: begin
        texel_read = 1'b1;
        state_n    = degen ? IDLE : EMIT;
      end
      EMIT: begin
        vtx_valid = 1'b1;
        if (vtx_ready && idx == 2'd2) state_n = BBOX;
      end
      BBOX: begin
        bbox_valid = 1'b1;
        if (bbox_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // bbox is registered on CHECK->EMIT so it stays stable through EMIT/BBOX and holds afterwards
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tri_q     <= '0;
      idx       <= '0;
      bbox_q    <= '0;
      tri_q_cnt <= '0;
    end else begin
      if (state == IDLE && texel_ready) tri_q <= texel_buffer;
      if (state == CHECK) begin
        idx <= '0;
        if (state_n == EMIT) bbox_q <= bbox_d;
      end
      if (vtx_valid && vtx_ready) idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (bbox_valid && bbox_ready) tri_q_cnt <= tri_q_cnt + CNT_W'(1);
    end
  end

`ifdef DEGEN_CULL_EN
  logic [CNT_W-1:0] cull_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                     cull_q <= '0;
    else if (state == CHECK && degen) cull_q <= cull_q + CNT_W'(1);
  end
  assign cull_count = cull_q;
`else
  assign cull_count = '0;
`endif

  logic [COORD_W-1:0] sel_x, sel_y, sel_z;
  logic [COLOR_W-1:0] sel_c;

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_z = '0;
    sel_c = '0;
    case (idx)
      2'd0: begin sel_x = vx[0]; sel_y = vy[0]; sel_z = vz[0]; sel_c = vc[0]; end
      2'd1: begin sel_x = vx[1]; sel_y = vy[1]; sel_z = vz[1]; sel_c = vc[1]; end
      2'd2: begin sel_x = vx[2]; sel_y = vy[2]; sel_z = vz[2]; sel_c = vc[2]; end
      default: ;
    endcase
  end

  assign vtx_x     = vtx_valid ? sel_x : '0;
  assign vtx_y     = vtx_valid ? sel_y : '0;
  assign vtx_z     = vtx_valid ? sel_z : '0;
  assign vtx_color = vtx_valid ? sel_c : '0;
  assign vtx_idx   = vtx_valid ? idx   : 2'd0;

  assign bbox_xmin = bbox_q.xmin;
  assign bbox_xmax = bbox_q.xmax;
  assign bbox_ymin = bbox_q.ymin;
  assign bbox_ymax = bbox_q.ymax;
  assign tri_count = tri_q_cnt;
endmodule

// File: tb/tb_triangle_vertex_unpacker.sv
// Scoreboard bench for triangle_vertex_unpacker: expected beats/bboxes queued at drive, checked on output.
module tb_triangle_vertex_unpacker;
  localparam int COORD_W = 16, COLOR_W = 8, CNT_W = 16;
  localparam int VTX_W = 56, TRI_W = 168;

  logic               clk, n_rst;
  logic [TRI_W-1:0]   texel_buffer;
  logic               texel_ready, texel_read;
  logic [COORD_W-1:0] vtx_x, vtx_y, vtx_z;
  logic [COLOR_W-1:0] vtx_color;
  logic [1:0]         vtx_idx;
  logic               vtx_valid, vtx_ready;
  logic [COORD_W-1:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
  logic               bbox_valid, bbox_ready;
  logic [CNT_W-1:0]   tri_count, cull_count;

  triangle_vertex_unpacker #(.COORD_W(COORD_W), .COLOR_W(COLOR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .texel_buffer(texel_buffer), .texel_ready(texel_ready),
    .texel_read(texel_read), .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z),
    .vtx_color(vtx_color), .vtx_idx(vtx_idx), .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
    .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
    .bbox_valid(bbox_valid), .bbox_ready(bbox_ready), .tri_count(tri_count),
    .cull_count(cull_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, rd_cnt = 0;
  logic [63:0] vq[$];
  logic [63:0] bq[$];
  logic [CNT_W-1:0] exp_tri = '0, exp_cull = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VTX_W-1:0] pv(input logic [15:0] x, y, z, input logic [7:0] c);
    return {x, y, z, c};
  endfunction

  // reference model: queue the three beats and the bbox, or count a cull
  task automatic push_exp(input logic [TRI_W-1:0] t);
    logic [VTX_W-1:0] v[3];
    logic [15:0] x[3], y[3];
    logic [15:0] xmn, xmx, ymn, ymx;
    bit deg;
    for (int k = 0; k < 3; k++) begin
      v[k] = t[VTX_W*k +: VTX_W];
      x[k] = v[k][55:40];
      y[k] = v[k][39:24];
    end
    deg = (x[0] == x[1] && y[0] == y[1]) || (x[0] == x[2] && y[0] == y[2]) ||
          (x[1] == x[2] && y[1] == y[2]);
`ifdef DEGEN_CULL_EN
    if (deg) begin
      exp_cull++;
      return;
    end
`else
    if (deg) ;
`endif
    xmn = x[0]; xmx = x[0]; ymn = y[0]; ymx = y[0];
    for (int k = 0; k < 3; k++) begin
      vq.push_back({4'd0, k[1:0], v[k]});
      if (x[k] < xmn) xmn = x[k];
      if (x[k] > xmx) xmx = x[k];
      if (y[k] < ymn) ymn = y[k];
      if (y[k] > ymx) ymx = y[k];
    end
    bq.push_back({xmn, xmx, ymn, ymx});
    exp_tri++;
  endtask

  // monitor: every vertex/bbox presentation is compared against the scoreboard head
  always @(negedge clk) begin
    if (texel_read) rd_cnt++;
    if (vtx_valid) begin
      if (vq.size() == 0) chk("vtx_extra_beat", vtx_valid, 1'b0);
      else begin
        chk("vtx_beat", {vtx_idx, vtx_x, vtx_y, vtx_z, vtx_color}, vq[0]);
        if (vtx_ready) void'(vq.pop_front());
      end
    end else chk("vtx_idle_zero", {vtx_idx, vtx_x, vtx_y, vtx_z, vtx_color}, 64'd0);
    if (bbox_valid) begin
      if (bq.size() == 0) chk("bbox_extra", bbox_valid, 1'b0);
      else begin
        chk("bbox", {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, bq[0]);
        if (bbox_ready) void'(bq.pop_front());
      end
    end
  end

  task automatic wait_read();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (texel_read) ok = 1;
    end
    if (!ok) chk("read_timeout", texel_read, 1'b1);
  endtask

  task automatic send(input logic [TRI_W-1:0] t);
    @(posedge clk); #1;
    texel_buffer = t;
    texel_ready  = 1'b1;
    push_exp(t);
    wait_read();
    texel_ready = 1'b0;
  endtask

  task automatic wait_beat(input logic [1:0] k);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (vtx_valid && vtx_idx == k) ok = 1;
    end
    if (!ok) chk("beat_timeout", vtx_idx, k);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!vtx_valid && !bbox_valid && !texel_read) done = 1;
    end
    chk("drain_timeout", done, 1'b1);
    @(negedge clk);
    chk("drain_vq", vq.size(), 64'd0);
    chk("drain_bq", bq.size(), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TRI_W-1:0] t2, ta, tb, td, tf;
    int rd0, acc_i;
    bit got;
    n_rst = 1'b0; texel_buffer = '0; texel_ready = 1'b0;
    vtx_ready = 1'b1; bbox_ready = 1'b1;
    t2 = {pv(15, 40, 9, 8'hCC), pv(30, 5, 7, 8'hBB), pv(10, 20, 5, 8'hAA)};
    ta = {pv(150, 300, 3, 8'h03), pv(200, 50, 2, 8'h02), pv(100, 100, 1, 8'h01)};
    tb = {pv(7, 4, 0, 8'h13), pv(7, 9, 0, 8'h12), pv(7, 1, 0, 8'h11)};
    td = {pv(50, 60, 3, 8'h03), pv(10, 10, 2, 8'h02), pv(10, 10, 1, 8'h01)};
    tf = {pv(9, 9, 9, 8'h99), pv(1, 2, 3, 8'h04), pv(500, 600, 700, 8'h55)};

    #12;
    chk("rst_vtx", {texel_read, vtx_valid, vtx_idx, vtx_x, vtx_y, vtx_z, vtx_color}, 64'd0);
    chk("rst_bbox", {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, 64'd0);
    chk("rst_cnt", {bbox_valid, tri_count, cull_count}, 64'd0);
    @(negedge clk); n_rst = 1'b1;

    // basic triangle with latency checks
    rd0 = rd_cnt;
    @(posedge clk); #1;
    texel_buffer = t2; texel_ready = 1'b1; push_exp(t2);
    @(negedge clk); chk("t2_read_pre", texel_read, 1'b0);
    @(negedge clk); chk("t2_check", {texel_read, vtx_valid}, 2'b10);
    texel_ready = 1'b0;
    @(negedge clk); chk("t2_first_beat", {texel_read, vtx_valid, vtx_idx}, {1'b0, 1'b1, 2'd0});
    @(negedge clk); chk("t2_second_beat", {vtx_valid, vtx_idx}, {1'b1, 2'd1});
    drain();
    chk("t2_bbox_hold", {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax},
        {16'd10, 16'd30, 16'd5, 16'd40});
    chk("t2_tri_count", tri_count, 16'd1);
    chk("t2_reads", rd_cnt - rd0, 1);

    // stall on idx1 for 5 cycles
    @(posedge clk); #1;
    texel_buffer = t2; texel_ready = 1'b1; push_exp(t2);
    wait_read();
    texel_ready = 1'b0;
    wait_beat(2'd0);
    @(posedge clk); #1; vtx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold", {vtx_valid, vtx_idx, vtx_x, vtx_y, vtx_z, vtx_color},
          {1'b1, 2'd1, 16'd30, 16'd5, 16'd7, 8'hBB});
    end
    vtx_ready = 1'b1;
    drain();
    chk("t3_tri_count", tri_count, 16'd2);

    // texel_ready held across two triangles
    rd0 = rd_cnt;
    @(posedge clk); #1;
    texel_buffer = ta; texel_ready = 1'b1; push_exp(ta);
    wait_read();
    texel_buffer = tb; push_exp(tb);
    acc_i = -100; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bbox_valid && bbox_ready) acc_i = i;
      if (texel_read) begin
        got = 1;
        chk("t4_gap", (i - acc_i >= 2 && i - acc_i < 100), 1'b1);
      end
    end
    if (!got) chk("t4_second_read", texel_read, 1'b1);
    texel_ready = 1'b0;
    drain();
    chk("t4_reads", rd_cnt - rd0, 2);
    chk("t4_tri_count", tri_count, exp_tri);
    chk("t4_bbox_flat", {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax},
        {16'd7, 16'd7, 16'd1, 16'd9});

    // degenerate triangle
    rd0 = rd_cnt;
    send(td);
    drain();
    chk("t5_reads", rd_cnt - rd0, 1);
    chk("t5_tri_count", tri_count, exp_tri);
    chk("t5_cull_count", cull_count, exp_cull);

    // reset during EMIT idx1, then a fresh triangle
    send(t2);
    wait_beat(2'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("t6_rst_vtx", {texel_read, vtx_valid, vtx_idx, vtx_x, vtx_y, vtx_z, vtx_color}, 64'd0);
    chk("t6_rst_bbox", {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, 64'd0);
    chk("t6_rst_cnt", {bbox_valid, tri_count, cull_count}, 64'd0);
    vq.delete(); bq.delete();
    exp_tri = '0; exp_cull = '0;
    @(posedge clk); @(negedge clk); n_rst = 1'b1;
    @(negedge clk);
    chk("t6_idle", {vtx_valid, bbox_valid, texel_read}, 3'b000);
    send(tf);
    @(negedge clk);
    chk("t6_restart", {vtx_valid, vtx_idx, vtx_x, vtx_y, vtx_z, vtx_color},
        {1'b1, 2'd0, 16'd500, 16'd600, 16'd700, 8'h55});
    drain();
    chk("t6_tri_count", tri_count, 16'd1);
    chk("t6_bbox", {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax},
        {16'd1, 16'd500, 16'd2, 16'd600});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
